// File: rtl/matmul_mac_sequencer_if.sv
// Bus bundle between the matmul sequencer and its surroundings: the start/busy/done
// handshake, the A and B operand read ports, the link to the `mac` unit and the
// C result write port. The sequencer uses the master modport.
interface matmul_mac_sequencer_if #(
  parameter int AW = 6
);
  // Handshake
  logic                 start;
  logic                 busy;
  logic                 done;
  // Operand memory A (synchronous read, data one cycle after address)
  logic [AW-1:0]        a_addr;
  logic signed [7:0]    a_rdata;
  // Operand memory B (synchronous read, data one cycle after address)
  logic [AW-1:0]        b_addr;
  logic signed [7:0]    b_rdata;
  // Multiply-accumulate unit
  logic signed [7:0]    mac_x;
  logic signed [7:0]    mac_y;
  logic                 mac_clear;
  logic signed [18:0]   mac_s;
  // Result memory C write port
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic signed [18:0]   wr_data;

  modport master (
    input  start, a_rdata, b_rdata, mac_s,
    output busy, done, a_addr, b_addr, mac_x, mac_y, mac_clear, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, a_rdata, b_rdata, mac_s,
    input  busy, done, a_addr, b_addr, mac_x, mac_y, mac_clear, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/matmul_mac_sequencer.sv
// Control stage in front of a `mac` unit computing C = A x B.
// For each C element (i, j) it issues INNER operand address pairs (FETCH), spends
// one cycle letting the last pair reach the accumulator (LAST), then writes the
// accumulator to C (WRITE). Operand data returns one cycle after its address, so
// a delayed issue flag and index steer the pair into the mac and raise mac_clear
// on the k = 0 pair, which restarts the sum without a separate zeroing cycle.
module matmul_mac_sequencer #(
  parameter int ROWS  = 8,
  parameter int INNER = 8,
  parameter int COLS  = 8,
  parameter int AW    = 6
) (
  input logic                    clk,
  input logic                    reset,
  matmul_mac_sequencer_if.master bus
);

  localparam int IW = (ROWS  > 1) ? $clog2(ROWS)  : 1;
  localparam int JW = (COLS  > 1) ? $clog2(COLS)  : 1;
  localparam int KW = (INNER > 1) ? $clog2(INNER) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAST,
    S_WRITE,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [IW-1:0]     i_q, i_d;
  logic [JW-1:0]     j_q, j_d;
  logic [KW-1:0]     k_q;
  logic              busy_q;
  logic              done_q;
  logic              wr_en_q;
  logic [AW-1:0]     a_addr_q;
  logic [AW-1:0]     b_addr_q;
  logic [AW-1:0]     wr_addr_q;

  // Operand-return tracking: one cycle behind the address issue.
  logic              v_q;
  logic [KW-1:0]     kd_q;

  logic signed [7:0] mac_x_c;
  logic signed [7:0] mac_y_c;
  logic              mac_clear_c;

  logic              k_last;
  logic              j_last;
  logic              i_last;

  assign k_last = (k_q == KW'(INNER - 1));
  assign j_last = (j_q == JW'(COLS - 1));
  assign i_last = (i_q == IW'(ROWS - 1));

  // Row-major addresses of A[i][k], B[k][j] and C[i][j].
  function automatic logic [AW-1:0] a_index(input logic [IW-1:0] i, input logic [KW-1:0] k);
    return AW'(int'(i) * INNER + int'(k));
  endfunction

  function automatic logic [AW-1:0] b_index(input logic [KW-1:0] k, input logic [JW-1:0] j);
    return AW'(int'(k) * COLS + int'(j));
  endfunction

  function automatic logic [AW-1:0] c_index(input logic [IW-1:0] i, input logic [JW-1:0] j);
    return AW'(int'(i) * COLS + int'(j));
  endfunction

  // Next C element: j sweeps fastest and wraps into the next row of i.
  always_comb begin
    // NOTE: each always_comb target gets a default first so no path can infer a latch.
    i_d = i_q;
    j_d = j_q + JW'(1);
    if (j_last) begin
      j_d = '0;
      i_d = i_q + IW'(1);
    end
  end

  // Control FSM: walks (i, j, k) and registers every strobe and address it drives.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
      wr_addr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q  <= S_FETCH;
            busy_q   <= 1'b1;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            a_addr_q <= a_index('0, '0);
            b_addr_q <= b_index('0, '0);
          end
        end
        S_FETCH: begin
          if (k_last) begin
            state_q <= S_LAST;
          end else begin
            k_q      <= k_q + KW'(1);
            a_addr_q <= a_index(i_q, k_q + KW'(1));
            b_addr_q <= b_index(k_q + KW'(1), j_q);
          end
        end
        S_LAST: begin
          // Final pair is entering the accumulator; the sum is ready next cycle.
          state_q   <= S_WRITE;
          wr_en_q   <= 1'b1;
          wr_addr_q <= c_index(i_q, j_q);
        end
        S_WRITE: begin
          if (i_last && j_last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q  <= S_FETCH;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= '0;
            a_addr_q <= a_index(i_d, '0);
            b_addr_q <= b_index('0, j_d);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          i_q     <= '0;
          j_q     <= '0;
          k_q     <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Delay the issue flag and k index to line up with the returning operand data.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q  <= 1'b0;
      kd_q <= '0;
    end else begin
      v_q  <= (state_q == S_FETCH);
      kd_q <= k_q;
    end
  end

  // Present a valid pair to the mac, or zeros so the accumulator holds its value.
  always_comb begin
    mac_x_c     = '0;
    mac_y_c     = '0;
    mac_clear_c = 1'b0;
    if (v_q) begin
      mac_x_c     = bus.a_rdata;
      mac_y_c     = bus.b_rdata;
      mac_clear_c = (kd_q == '0);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.a_addr    = a_addr_q;
  assign bus.b_addr    = b_addr_q;
  assign bus.mac_x     = mac_x_c;
  assign bus.mac_y     = mac_y_c;
  assign bus.mac_clear = mac_clear_c;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  // The accumulator holds the finished sum throughout the WRITE cycle.
  assign bus.wr_data   = wr_en_q ? bus.mac_s : '0;

endmodule

// File: tb/tb_matmul_mac_sequencer.sv
// Bench for matmul_mac_sequencer: three instances (2x2x2, 2x1x2, 8x8x8) each with
// behavioural operand memories and a mac model. C results, write order, write
// timing, clear placement and done timing are compared against values derived
// from plain matrix arithmetic and the element-time formula.
module tb_matmul_mac_sequencer;

  typedef struct {
    int addr;
    int data;
    int cyc;
    int clrs;
  } wr_t;

  typedef struct {
    int a[4];
    int b[4];
    int c[4];
  } mat_vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic signed [18:0] mac_next(input logic clr, input logic signed [7:0] x,
                                                  input logic signed [7:0] y,
                                                  input logic signed [18:0] s);
    int p;
    p = int'(x) * int'(y);
    return clr ? 19'(p) : 19'(int'(s) + p);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- 2x2x2 instance ----------------
  matmul_mac_sequencer_if #(.AW(2)) sm_if ();
  matmul_mac_sequencer #(.ROWS(2), .INNER(2), .COLS(2), .AW(2)) u_sm (
    .clk(clk), .reset(reset), .bus(sm_if));
  logic signed [7:0] sm_a [4];
  logic signed [7:0] sm_b [4];
  wr_t  sm_wq[$];
  int   sm_dq[$];
  int   sm_clr_since = 0, sm_clr_total = 0, sm_fetch = -1, sm_start = 0;
  logic sm_busy_prev = 1'b0;

  always @(posedge clk) begin
    sm_if.a_rdata <= sm_a[sm_if.a_addr];
    sm_if.b_rdata <= sm_b[sm_if.b_addr];
    sm_if.mac_s   <= mac_next(sm_if.mac_clear, sm_if.mac_x, sm_if.mac_y, sm_if.mac_s);
  end

  always @(negedge clk) begin
    if (sm_if.mac_clear) begin sm_clr_since++; sm_clr_total++; end
    if (sm_if.wr_en) begin
      sm_wq.push_back(wr_t'{int'(sm_if.wr_addr), int'(sm_if.wr_data), cyc, sm_clr_since});
      sm_clr_since = 0;
    end
    if (sm_if.done) sm_dq.push_back(cyc);
    if (sm_if.busy && !sm_busy_prev && sm_fetch < 0) sm_fetch = cyc;
    sm_busy_prev = sm_if.busy;
  end

  // ---------------- 2x1x2 instance (INNER = 1) ----------------
  matmul_mac_sequencer_if #(.AW(2)) in1_if ();
  matmul_mac_sequencer #(.ROWS(2), .INNER(1), .COLS(2), .AW(2)) u_in1 (
    .clk(clk), .reset(reset), .bus(in1_if));
  logic signed [7:0] in1_a [4];
  logic signed [7:0] in1_b [4];
  wr_t  in1_wq[$];
  int   in1_dq[$];
  int   in1_clr_since = 0, in1_clr_total = 0, in1_fetch = -1, in1_start = 0;
  logic in1_busy_prev = 1'b0;

  always @(posedge clk) begin
    in1_if.a_rdata <= in1_a[in1_if.a_addr];
    in1_if.b_rdata <= in1_b[in1_if.b_addr];
    in1_if.mac_s   <= mac_next(in1_if.mac_clear, in1_if.mac_x, in1_if.mac_y, in1_if.mac_s);
  end

  always @(negedge clk) begin
    if (in1_if.mac_clear) begin in1_clr_since++; in1_clr_total++; end
    if (in1_if.wr_en) begin
      in1_wq.push_back(wr_t'{int'(in1_if.wr_addr), int'(in1_if.wr_data), cyc, in1_clr_since});
      in1_clr_since = 0;
    end
    if (in1_if.done) in1_dq.push_back(cyc);
    if (in1_if.busy && !in1_busy_prev && in1_fetch < 0) in1_fetch = cyc;
    in1_busy_prev = in1_if.busy;
  end

  // ---------------- 8x8x8 instance ----------------
  matmul_mac_sequencer_if #(.AW(6)) bg_if ();
  matmul_mac_sequencer #(.ROWS(8), .INNER(8), .COLS(8), .AW(6)) u_bg (
    .clk(clk), .reset(reset), .bus(bg_if));
  logic signed [7:0] bg_a [64];
  logic signed [7:0] bg_b [64];
  wr_t  bg_wq[$];
  int   bg_dq[$];
  int   bg_clr_since = 0, bg_clr_total = 0, bg_fetch = -1, bg_start = 0;
  logic bg_busy_prev = 1'b0;

  always @(posedge clk) begin
    bg_if.a_rdata <= bg_a[bg_if.a_addr];
    bg_if.b_rdata <= bg_b[bg_if.b_addr];
    bg_if.mac_s   <= mac_next(bg_if.mac_clear, bg_if.mac_x, bg_if.mac_y, bg_if.mac_s);
  end

  always @(negedge clk) begin
    if (bg_if.mac_clear) begin bg_clr_since++; bg_clr_total++; end
    if (bg_if.wr_en) begin
      bg_wq.push_back(wr_t'{int'(bg_if.wr_addr), int'(bg_if.wr_data), cyc, bg_clr_since});
      bg_clr_since = 0;
    end
    if (bg_if.done) bg_dq.push_back(cyc);
    if (bg_if.busy && !bg_busy_prev && bg_fetch < 0) bg_fetch = cyc;
    bg_busy_prev = bg_if.busy;
  end

  // ---------------- shared comparison of one captured run ----------------
  wr_t cur_wq[$];
  int  cur_dq[$];
  int  cur_exp [64];
  int  cur_fetch, cur_start, cur_clr;

  task automatic cmp_run(input string tag, input int nel, input int inner);
    int n;
    check({tag, " first FETCH after start"}, cur_fetch - cur_start, 1);
    check({tag, " write count"}, cur_wq.size(), nel);
    check({tag, " mac_clear count"}, cur_clr, nel);
    check({tag, " done count"}, cur_dq.size(), 1);
    if (cur_dq.size() > 0) check({tag, " done latency"}, cur_dq[0] - cur_fetch, nel * (inner + 2));
    n = (cur_wq.size() < nel) ? cur_wq.size() : nel;
    for (int e = 0; e < n; e++) begin
      check($sformatf("%s wr%0d addr", tag, e), cur_wq[e].addr, e);
      check($sformatf("%s wr%0d data", tag, e), cur_wq[e].data, cur_exp[e]);
      check($sformatf("%s wr%0d cycle", tag, e), cur_wq[e].cyc - cur_fetch, e * (inner + 2) + inner + 1);
      check($sformatf("%s wr%0d clears", tag, e), cur_wq[e].clrs, 1);
    end
  endtask

  // Reference: C[i][j] = sum_k A[i][k] * B[k][j] in plain integer arithmetic.
  function automatic void bg_model();
    int acc;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        acc = 0;
        for (int k = 0; k < 8; k++) acc += int'(bg_a[i*8+k]) * int'(bg_b[k*8+j]);
        cur_exp[i*8+j] = acc;
      end
  endfunction

  task automatic sm_go();
    @(posedge clk); #1;
    sm_wq.delete(); sm_dq.delete(); sm_clr_since = 0; sm_clr_total = 0; sm_fetch = -1;
    @(negedge clk); sm_start = cyc; sm_if.start = 1'b1;
    @(negedge clk); sm_if.start = 1'b0;
  endtask

  task automatic sm_wait(input int budget);
    for (int c = 0; c < budget && sm_dq.size() == 0; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    cur_wq = sm_wq; cur_dq = sm_dq; cur_fetch = sm_fetch; cur_start = sm_start; cur_clr = sm_clr_total;
  endtask

  task automatic in1_go();
    @(posedge clk); #1;
    in1_wq.delete(); in1_dq.delete(); in1_clr_since = 0; in1_clr_total = 0; in1_fetch = -1;
    @(negedge clk); in1_start = cyc; in1_if.start = 1'b1;
    @(negedge clk); in1_if.start = 1'b0;
  endtask

  task automatic in1_wait(input int budget);
    for (int c = 0; c < budget && in1_dq.size() == 0; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    cur_wq = in1_wq; cur_dq = in1_dq; cur_fetch = in1_fetch; cur_start = in1_start; cur_clr = in1_clr_total;
  endtask

  task automatic bg_go();
    @(posedge clk); #1;
    bg_wq.delete(); bg_dq.delete(); bg_clr_since = 0; bg_clr_total = 0; bg_fetch = -1;
    @(negedge clk); bg_start = cyc; bg_if.start = 1'b1;
    @(negedge clk); bg_if.start = 1'b0;
  endtask

  task automatic bg_wait(input int budget);
    for (int c = 0; c < budget && bg_dq.size() == 0; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    cur_wq = bg_wq; cur_dq = bg_dq; cur_fetch = bg_fetch; cur_start = bg_start; cur_clr = bg_clr_total;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got no summary, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mat_vec_t sm_tab [4];
    int       late_wr;
    int       rst_cyc;

    // 2x2 cases: A, B row-major; C worked out by hand.
    sm_tab[0].a = '{1, 2, 3, 4};         sm_tab[0].b = '{1, 0, 0, 1};
    sm_tab[0].c = '{1, 2, 3, 4};
    sm_tab[1].a = '{1, 2, 3, 4};         sm_tab[1].b = '{5, 6, 7, 8};
    sm_tab[1].c = '{19, 22, 43, 50};
    sm_tab[2].a = '{-128, -128, -128, -128}; sm_tab[2].b = '{-128, 127, -128, 127};
    sm_tab[2].c = '{32768, -32512, 32768, -32512};
    sm_tab[3].a = '{127, -1, 0, 5};      sm_tab[3].b = '{2, -3, 4, 0};
    sm_tab[3].c = '{250, -381, 20, 0};

    for (int n = 0; n < 4; n++) begin
      sm_a[n] = '0; sm_b[n] = '0; in1_a[n] = '0; in1_b[n] = '0;
    end
    for (int n = 0; n < 64; n++) begin bg_a[n] = '0; bg_b[n] = '0; end

    // Reset held 3 cycles with start asserted alongside it: reset must win.
    reset = 1'b1;
    sm_if.start = 1'b1; in1_if.start = 1'b1; bg_if.start = 1'b1;
    repeat (3) @(negedge clk);
    check("busy during reset+start", bg_if.busy, 0);
    reset = 1'b0;
    sm_if.start = 1'b0; in1_if.start = 1'b0; bg_if.start = 1'b0;
    @(negedge clk);
    check("reset busy",      bg_if.busy, 0);
    check("reset done",      bg_if.done, 0);
    check("reset wr_en",     bg_if.wr_en, 0);
    check("reset mac_clear", bg_if.mac_clear, 0);
    check("reset mac_x",     int'(bg_if.mac_x), 0);
    check("reset mac_y",     int'(bg_if.mac_y), 0);
    check("reset a_addr",    int'(bg_if.a_addr), 0);
    check("reset b_addr",    int'(bg_if.b_addr), 0);
    check("reset wr_addr",   int'(bg_if.wr_addr), 0);
    check("reset wr_data",   int'(bg_if.wr_data), 0);
    check("reset sm busy",   sm_if.busy, 0);
    check("reset in1 busy",  in1_if.busy, 0);

    // Table-driven 2x2x2 runs.
    for (int t = 0; t < 4; t++) begin
      for (int n = 0; n < 4; n++) begin
        sm_a[n] = 8'(sm_tab[t].a[n]);
        sm_b[n] = 8'(sm_tab[t].b[n]);
        cur_exp[n] = sm_tab[t].c[n];
      end
      sm_go();
      sm_wait(60);
      cmp_run($sformatf("2x2 case%0d", t), 4, 2);
    end

    // start during the DONE cycle is ignored.
    for (int n = 0; n < 4; n++) begin sm_a[n] = 8'(sm_tab[0].a[n]); sm_b[n] = 8'(sm_tab[0].b[n]); end
    sm_go();
    for (int c = 0; c < 60 && !sm_if.done; c++) @(negedge clk);
    sm_if.start = 1'b1;
    @(negedge clk);
    sm_if.start = 1'b0;
    check("start in DONE busy", sm_if.busy, 0);
    repeat (6) @(negedge clk);
    check("start in DONE still idle", sm_if.busy, 0);
    check("start in DONE writes", sm_wq.size(), 4);

    // INNER = 1: outer product, every element loaded with mac_clear.
    in1_a[0] = 8'sd3; in1_a[1] = -8'sd7;
    in1_b[0] = 8'sd5; in1_b[1] = -8'sd2;
    cur_exp[0] = 15; cur_exp[1] = -6; cur_exp[2] = -35; cur_exp[3] = 14;
    in1_go();
    in1_wait(60);
    cmp_run("inner1", 4, 1);

    // 8x8x8: all -128 gives 131072 per element.
    for (int n = 0; n < 64; n++) begin bg_a[n] = -8'sd128; bg_b[n] = -8'sd128; end
    bg_model();
    bg_go(); bg_wait(800);
    cmp_run("all-128", 64, 8);

    // 8x8x8: A = -1, B = 2 gives -16 per element.
    for (int n = 0; n < 64; n++) begin bg_a[n] = -8'sd1; bg_b[n] = 8'sd2; end
    bg_model();
    bg_go(); bg_wait(800);
    cmp_run("neg1x2", 64, 8);

    // Random operands.
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < 64; n++) begin bg_a[n] = 8'($urandom); bg_b[n] = 8'($urandom); end
      bg_model();
      bg_go(); bg_wait(800);
      cmp_run($sformatf("random%0d", r), 64, 8);
    end

    // start pulsed again mid-run is ignored.
    for (int n = 0; n < 64; n++) begin bg_a[n] = 8'($urandom); bg_b[n] = 8'($urandom); end
    bg_model();
    bg_go();
    repeat (100) @(negedge clk);
    bg_if.start = 1'b1;
    @(negedge clk);
    bg_if.start = 1'b0;
    bg_wait(800);
    cmp_run("restart ignored", 64, 8);

    // Reset during the third element's FETCH: no further writes or done.
    bg_go();
    for (int c = 0; c < 200 && !(bg_fetch >= 0 && cyc >= bg_fetch + 22); c++) @(negedge clk);
    reset = 1'b1;
    rst_cyc = cyc;
    @(negedge clk);
    reset = 1'b0;
    check("mid reset busy", bg_if.busy, 0);
    check("mid reset wr_en", bg_if.wr_en, 0);
    repeat (40) @(negedge clk);
    late_wr = 0;
    foreach (bg_wq[e]) if (bg_wq[e].cyc > rst_cyc) late_wr++;
    check("mid reset late writes", late_wr, 0);
    check("mid reset writes before", bg_wq.size(), 2);
    check("mid reset done", bg_dq.size(), 0);

    // A fresh start after the aborted run produces a full, correct C.
    bg_go(); bg_wait(800);
    cmp_run("after reset", 64, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
